regfile_multiport: RTL and testbench

Parametrised integer register file for the RISC-V core datapath, successor to the fixed 32x32, two-read-port register file. Width, depth and read-port count are configurable. Entry 0 is hardwired to zero. A synchronous reset starts a hardware clear sweep that zeroes every entry, so the array needs no initial block and maps cleanly to distributed RAM. Optional write-to-read bypass forwards same-cycle writeback to the decode stage.

---
 rtl/regfile_multiport.sv | 85 ++++++++
 tb/tb_regfile_multiport.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Parametrised integer register file: entry 0 reads as zero, synchronous reset starts a clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          write_addr,
  input  logic [DATA_WIDTH-1:0]          write_back,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic                           busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_idx;
  logic [DATA_WIDTH-1:0]   regs [DEPTH];

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      if (clr_idx == '1) begin
        state   <= IDLE;
        clr_idx <= '0;
      end else begin
        clr_idx <= clr_idx + ADDR_WIDTH'(1);
      end
    end
  end

  assign busy = (state == CLEAR);

  // Reset, sweep and writeback share one write port so the array stays a simple RAM.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (rst) begin
      wr_en = 1'b1;
    end else if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_idx;
    end else if (we && write_addr != '0) begin
      wr_en   = 1'b1;
      wr_addr = write_addr;
      wr_data = write_back;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) regs[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NUM_READ; k++) begin
      logic [ADDR_WIDTH-1:0] ra;
      ra = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (!busy && ra != '0) begin
`ifdef REGFILE_BYPASS_EN
        if (we && write_addr != '0 && ra == write_addr)
          rd_data[k*DATA_WIDTH +: DATA_WIDTH] = write_back;
        else
          rd_data[k*DATA_WIDTH +: DATA_WIDTH] = regs[ra];
`else
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] = regs[ra];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport (default parameters) against an array-based model.
module tb_regfile_multiport;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             we = 1'b0;
  logic [AW-1:0]    write_addr = '0;
  logic [DW-1:0]    write_back = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model [DEPTH];
  int            sweep_left = DEPTH;

  regfile_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
    .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .write_back(write_back),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_rd(input int p);
    logic [AW-1:0] a;
    a = rd_addr[p*AW +: AW];
    if (sweep_left > 0 || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && write_addr != 0 && a == write_addr) return write_back;
`endif
    return model[a];
  endfunction

  task automatic check(input string tag);
    logic [DW-1:0] got;
    logic [DW-1:0] exp;
    n_checks++;
    assert (busy === (sweep_left > 0)) else begin
      n_fail++;
      $error("FAIL %s busy: got %b expected %b", tag, busy, sweep_left > 0);
    end
    for (int p = 0; p < NR; p++) begin
      got = rd_data[p*DW +: DW];
      exp = exp_rd(p);
      n_checks++;
      assert (got === exp) else begin
        n_fail++;
        $error("FAIL %s port%0d: got %h expected %h", tag, p, got, exp);
      end
    end
  endtask

  // One rising edge; the model advances from the inputs held across that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      sweep_left = DEPTH;
    end else if (sweep_left > 0) begin
      sweep_left--;
      if (sweep_left == 0)
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else if (we && write_addr != 0) begin
      model[write_addr] = write_back;
    end
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic set_wr(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = w; write_addr = a; write_back = d;
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < DEPTH; i++) model[i] = 'x;

    // Reset held for three edges
    rst = 1'b1;
    set_rd(5'd3, 5'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset");
    end
    rst = 1'b0;

    // Sweep with a dropped write at cycle 10 and a reset pulse at cycle 20
    for (int c = 1; c <= 20; c++) begin
      set_wr(c == 10, 5'd7, 32'hAAAA5555);
      rst = (c == 20);
      set_rd(5'd7, AW'(c));
      #1 check("sweep_pre");
      tick();
    end
    rst = 1'b0;
    set_wr(1'b0, '0, '0);

    // Restarted sweep: busy must stay high for exactly DEPTH edges
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      set_wr(cnt == 9, 5'd7, 32'hAAAA5555);
      tick();
      cnt++;
      check("sweep2");
    end
    set_wr(1'b0, '0, '0);
    n_checks++;
    assert (cnt == DEPTH) else begin
      n_fail++;
      $error("FAIL sweep_len: got %0d edges expected %0d", cnt, DEPTH);
    end

    // All entries cleared, including x7 written during the sweep
    for (int a = 0; a < DEPTH; a += 2) begin
      set_rd(AW'(a), AW'(a + 1));
      #1 check("cleared");
    end

    // Basic write/read
    set_wr(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    set_wr(1'b0, '0, '0);
    set_rd(5'd5, 5'd5);
    #1 check("x5_both_ports");

    // Zero register
    set_wr(1'b1, 5'd0, 32'h12345678);
    set_rd(5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      set_wr(1'b0, '0, '0);
      check("x0");
    end

    // Bypass/hazard on x9
    set_wr(1'b1, 5'd9, 32'h11111111);
    tick();
    set_wr(1'b1, 5'd9, 32'h0000CAFE);
    set_rd(5'd5, 5'd9);
    #1 check("x9_same_cycle");
    tick();
    set_wr(1'b0, '0, '0);
    #1 check("x9_after_edge");

    // Randomised traffic, occasional resets
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      set_wr($urandom_range(0, 1) == 1, AW'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) write_addr = rd_addr[AW +: AW];
      set_rd(AW'($urandom), AW'($urandom));
      #1 check("rand_pre");
      tick();
      check("rand_post");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
